// File: rtl/fpnew_pkg.sv
// Shared FPU definitions: format count, status flags and a wrap-around index helper
// used by the round-robin arbiters.
package fpnew_pkg;

    localparam int unsigned NUM_FP_FORMATS = 5;

    typedef struct packed {
        logic NV;
        logic DZ;
        logic OF;
        logic UF;
        logic NX;
    } status_t;

    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/fpnew_rr_lock_arbiter.sv
// Round-robin arbiter with grant lock: once an offered output is stalled, the
// grant is frozen on that requester until the downstream accepts it.
module fpnew_rr_lock_arbiter
    import fpnew_pkg::*;
#(
    parameter int unsigned NumReq = 5,
    parameter type data_t = logic,
    localparam int unsigned IdxWidth = $clog2(NumReq)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                flush_i,
    input  logic [NumReq-1:0]   req_valid_i,
    output logic [NumReq-1:0]   req_ready_o,
    input  data_t               req_data_i [NumReq],
    output data_t               out_data_o,
    output logic [IdxWidth-1:0] out_idx_o,
    output logic                out_valid_o,
    input  logic                out_ready_i
);

    logic [IdxWidth-1:0] rr_ptr_q, lock_idx_q, grant;
    logic                lock_q;
    int                  cand;

    always_comb begin
        grant = '0;
        cand  = 0;
        if (lock_q) begin
            grant = lock_idx_q;
        end else begin
            // Walk from the farthest offset back so the nearest valid requester wins.
            for (int i = int'(NumReq) - 1; i >= 0; i--) begin
                cand = int'(rr_ptr_q) + i;
                if (cand >= int'(NumReq)) cand = cand - int'(NumReq);
                if (req_valid_i[IdxWidth'(cand)]) grant = IdxWidth'(cand);
            end
        end
        out_valid_o        = (|req_valid_i) & ~flush_i & ~rst_i;
        req_ready_o        = '0;
        req_ready_o[grant] = out_ready_i & ~flush_i & ~rst_i;
        out_data_o         = req_data_i[grant];
        out_idx_o          = grant;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            rr_ptr_q   <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else if (out_valid_o) begin
            if (out_ready_i) begin
                lock_q   <= 1'b0;
                rr_ptr_q <= IdxWidth'(rr_next(32'(grant), NumReq));
            end else begin
                lock_q     <= 1'b1;
                lock_idx_q <= grant;
            end
        end
    end

endmodule

// File: rtl/fpnew_opgroup_fmt_sched.sv
// Per-format dispatch, in-flight limiting and result merging for one opgroup's
// format slices.
module fpnew_opgroup_fmt_sched
    import fpnew_pkg::*;
#(
    parameter int unsigned NumSlices   = NUM_FP_FORMATS,
    parameter int unsigned Width       = 64,
    parameter int unsigned MaxInFlight = 8,
    parameter type         TagType     = logic,
    localparam int unsigned IdxWidth   = $clog2(NumSlices)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 in_valid_i,
    input  logic [IdxWidth-1:0]  in_fmt_i,
    output logic                 in_ready_o,
    input  logic                 flush_i,
    output logic [NumSlices-1:0] slice_in_valid_o,
    input  logic [NumSlices-1:0] slice_in_ready_i,
    input  logic [Width-1:0]     slice_result_i [NumSlices],
    input  status_t              slice_status_i [NumSlices],
    input  logic [NumSlices-1:0] slice_ext_bit_i,
    input  TagType               slice_tag_i [NumSlices],
    input  logic [NumSlices-1:0] slice_out_valid_i,
    output logic [NumSlices-1:0] slice_out_ready_o,
    output logic [Width-1:0]     result_o,
    output status_t              status_o,
    output logic                 extension_bit_o,
    output TagType               tag_o,
    output logic [IdxWidth-1:0]  out_idx_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic                 busy_o
);

    localparam int unsigned CntWidth = $clog2(MaxInFlight + 1);

    typedef struct packed {
        logic [Width-1:0] result;
        status_t          status;
        logic             ext;
        TagType           tag;
    } payload_t;

    logic [CntWidth-1:0] cnt_q;
    logic                full, fmt_ok, accept_ok, in_fire, out_fire;
    payload_t            payload [NumSlices];
    payload_t            out_payload;

    assign full      = (cnt_q == CntWidth'(MaxInFlight));
    assign fmt_ok    = (32'(in_fmt_i) < NumSlices);
    assign accept_ok = ~full & ~flush_i & ~rst_i;
    assign in_ready_o = fmt_ok & slice_in_ready_i[in_fmt_i] & accept_ok;
    assign in_fire   = in_valid_i & in_ready_o;
    assign out_fire  = out_valid_o & out_ready_i;
    assign busy_o    = (cnt_q != '0);

    generate
        for (genvar gi = 0; gi < int'(NumSlices); gi++) begin : g_slice
            assign slice_in_valid_o[gi] = in_valid_i & (in_fmt_i == IdxWidth'(gi)) & accept_ok;
            assign payload[gi] = '{slice_result_i[gi], slice_status_i[gi],
                                   slice_ext_bit_i[gi], slice_tag_i[gi]};
        end
    endgenerate

    fpnew_rr_lock_arbiter #(
        .NumReq (NumSlices),
        .data_t (payload_t)
    ) u_arb (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .req_valid_i (slice_out_valid_i),
        .req_ready_o (slice_out_ready_o),
        .req_data_i  (payload),
        .out_data_o  (out_payload),
        .out_idx_o   (out_idx_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i)
    );

    assign result_o        = out_payload.result;
    assign status_o        = out_payload.status;
    assign extension_bit_o = out_payload.ext;
    assign tag_o           = out_payload.tag;

    // Full blocks input outright, so the counter cannot pass MaxInFlight.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            cnt_q <= '0;
        end else if (in_fire && !out_fire) begin
            cnt_q <= cnt_q + 1'b1;
        end else if (out_fire && !in_fire && cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

`ifndef SYNTHESIS
    fmt_in_range: assert property (@(posedge clk_i) disable iff (rst_i)
        in_valid_i |-> (32'(in_fmt_i) < NumSlices));
    no_cnt_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
        out_fire |-> (cnt_q != '0));
`endif

endmodule

// File: tb/tb_fpnew_opgroup_fmt_sched.sv
// Directed scenario bench for the opgroup format scheduler.
module tb_fpnew_opgroup_fmt_sched;
    import fpnew_pkg::*;

    localparam int NS = 5;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, flush, ext, tag, out_valid, out_ready, busy;
    logic [2:0]  in_fmt, out_idx;
    logic [4:0]  s_in_valid, s_in_ready, s_ext, s_out_valid, s_out_ready;
    logic [63:0] s_result [NS];
    status_t     s_status [NS];
    logic        s_tag [NS];
    logic [63:0] result;
    status_t     status;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fpnew_opgroup_fmt_sched dut (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_fmt_i(in_fmt),
        .in_ready_o(in_ready), .flush_i(flush), .slice_in_valid_o(s_in_valid),
        .slice_in_ready_i(s_in_ready), .slice_result_i(s_result), .slice_status_i(s_status),
        .slice_ext_bit_i(s_ext), .slice_tag_i(s_tag), .slice_out_valid_i(s_out_valid),
        .slice_out_ready_o(s_out_ready), .result_o(result), .status_o(status),
        .extension_bit_o(ext), .tag_o(tag), .out_idx_o(out_idx), .out_valid_o(out_valid),
        .out_ready_i(out_ready), .busy_o(busy)
    );

    function automatic logic [63:0] res(input int k);
        return 64'hC0DE_0000_0000_0000 | 64'(k * 17 + 3);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1; in_valid = 1; in_fmt = 0; s_out_valid = '1; out_ready = 1;
        tick;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
        total++; if (s_in_valid !== 5'b0) begin bad++; $display("FAIL rst_slice_in_valid got=%b exp=00000", s_in_valid); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        total++; if (s_out_ready !== 5'b0) begin bad++; $display("FAIL rst_slice_out_ready got=%b exp=00000", s_out_ready); end
        in_valid = 0; s_out_valid = '0; out_ready = 0;
        tick;
        rst = 0;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
        total++; if (dut.cnt_q !== 4'd0) begin bad++; $display("FAIL rst_cnt got=%0d exp=0", dut.cnt_q); end
        total++; if (result !== res(0)) begin bad++; $display("FAIL idle_result got=%h exp=%h", result, res(0)); end
        total++; if (out_idx !== 3'd0) begin bad++; $display("FAIL idle_idx got=%0d exp=0", out_idx); end
        $display("txn reset: busy=%b out_valid=%b", busy, out_valid);
    endtask

    task automatic test_dispatch;
        in_valid = 1; in_fmt = 2;
        #1;
        total++; if (s_in_valid !== 5'b00100) begin bad++; $display("FAIL disp_slice_valid got=%b exp=00100", s_in_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL disp_in_ready got=%b exp=1", in_ready); end
        tick;
        in_valid = 0;
        #1;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL disp_busy got=%b exp=1", busy); end
        total++; if (dut.cnt_q !== 4'd1) begin bad++; $display("FAIL disp_cnt got=%0d exp=1", dut.cnt_q); end
        $display("txn dispatch fmt=2: cnt=%0d", dut.cnt_q);
    endtask

    task automatic test_full;
        in_valid = 1;
        for (int i = 0; i < 7; i++) begin
            in_fmt = 3'(i % 5);
            tick;
        end
        total++; if (dut.cnt_q !== 4'd8) begin bad++; $display("FAIL full_cnt got=%0d exp=8", dut.cnt_q); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_in_ready got=%b exp=0", in_ready); end
        total++; if (s_in_valid !== 5'b0) begin bad++; $display("FAIL full_slice_valid got=%b exp=00000", s_in_valid); end
        s_out_valid = 5'b00010; out_ready = 1;
        #1;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL full_out_valid got=%b exp=1", out_valid); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_no_bypass got=%b exp=0", in_ready); end
        tick;
        s_out_valid = '0; out_ready = 0;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL full_reopen got=%b exp=1", in_ready); end
        total++; if (dut.cnt_q !== 4'd7) begin bad++; $display("FAIL full_cnt_after got=%0d exp=7", dut.cnt_q); end
        in_valid = 0;
        $display("txn full stall: cnt=%0d in_ready=%b", dut.cnt_q, in_ready);
    endtask

    task automatic test_lock;
        s_out_valid = 5'b01000; out_ready = 0;
        #1;
        total++; if (out_idx !== 3'd3) begin bad++; $display("FAIL lock_first_idx got=%0d exp=3", out_idx); end
        total++; if (result !== res(3)) begin bad++; $display("FAIL lock_first_res got=%h exp=%h", result, res(3)); end
        tick;
        s_out_valid = 5'b01001;
        #1;
        total++; if (out_idx !== 3'd3) begin bad++; $display("FAIL lock_hold_idx got=%0d exp=3", out_idx); end
        total++; if (result !== res(3)) begin bad++; $display("FAIL lock_hold_res got=%h exp=%h", result, res(3)); end
        total++; if (s_out_ready !== 5'b0) begin bad++; $display("FAIL lock_stall_ready got=%b exp=00000", s_out_ready); end
        tick;
        total++; if (out_idx !== 3'd3) begin bad++; $display("FAIL lock_hold2_idx got=%0d exp=3", out_idx); end
        out_ready = 1;
        #1;
        total++; if (s_out_ready !== 5'b01000) begin bad++; $display("FAIL lock_accept_ready got=%b exp=01000", s_out_ready); end
        tick;
        s_out_valid = 5'b00001; out_ready = 0;
        #1;
        total++; if (out_idx !== 3'd0) begin bad++; $display("FAIL lock_wrap_idx got=%0d exp=0", out_idx); end
        total++; if (dut.cnt_q !== 4'd6) begin bad++; $display("FAIL lock_cnt got=%0d exp=6", dut.cnt_q); end
        out_ready = 1;
        tick;
        s_out_valid = '0; out_ready = 0;
        $display("txn lock: next grant after 3 was 0, cnt=%0d", dut.cnt_q);
    endtask

    task automatic test_simultaneous;
        total++; if (dut.cnt_q !== 4'd5) begin bad++; $display("FAIL sim_cnt_before got=%0d exp=5", dut.cnt_q); end
        in_valid = 1; in_fmt = 0; s_out_valid = 5'b00100; out_ready = 1;
        #1;
        total++; if ((in_ready & out_valid) !== 1'b1) begin bad++; $display("FAIL sim_both_fire got=%b exp=1", in_ready & out_valid); end
        tick;
        in_valid = 0; s_out_valid = '0; out_ready = 0;
        #1;
        total++; if (dut.cnt_q !== 4'd5) begin bad++; $display("FAIL sim_cnt_after got=%0d exp=5", dut.cnt_q); end
        $display("txn in+out same cycle: cnt=%0d", dut.cnt_q);
    endtask

    task automatic test_flush;
        in_valid = 1; in_fmt = 1;
        tick;
        in_valid = 0; s_out_valid = 5'b10000; out_ready = 0;
        tick;
        total++; if (dut.cnt_q !== 4'd6) begin bad++; $display("FAIL flush_cnt_before got=%0d exp=6", dut.cnt_q); end
        total++; if (dut.u_arb.lock_q !== 1'b1) begin bad++; $display("FAIL flush_lock_before got=%b exp=1", dut.u_arb.lock_q); end
        flush = 1; in_valid = 1; out_ready = 1;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_out_valid got=%b exp=0", out_valid); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_in_ready got=%b exp=0", in_ready); end
        total++; if (s_out_ready !== 5'b0) begin bad++; $display("FAIL flush_slice_ready got=%b exp=00000", s_out_ready); end
        tick;
        flush = 0; in_valid = 0; s_out_valid = '0; out_ready = 0;
        #1;
        total++; if (dut.cnt_q !== 4'd0) begin bad++; $display("FAIL flush_cnt got=%0d exp=0", dut.cnt_q); end
        total++; if (dut.u_arb.lock_q !== 1'b0) begin bad++; $display("FAIL flush_lock got=%b exp=0", dut.u_arb.lock_q); end
        total++; if (dut.u_arb.rr_ptr_q !== 3'd0) begin bad++; $display("FAIL flush_ptr got=%0d exp=0", dut.u_arb.rr_ptr_q); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_busy got=%b exp=0", busy); end
        $display("txn flush: cnt=%0d busy=%b", dut.cnt_q, busy);
    endtask

    task automatic test_round_robin;
        logic [2:0] exp_idx [6];
        exp_idx = '{3'd0, 3'd1, 3'd3, 3'd0, 3'd1, 3'd3};
        in_valid = 1; in_fmt = 4;
        repeat (6) tick;
        in_valid = 0;
        s_out_valid = 5'b01011; out_ready = 1;
        for (int i = 0; i < 6; i++) begin
            #1;
            total++; if (out_idx !== exp_idx[i]) begin bad++; $display("FAIL rr_idx[%0d] got=%0d exp=%0d", i, out_idx, exp_idx[i]); end
            total++; if (result !== res(int'(exp_idx[i]))) begin bad++; $display("FAIL rr_res[%0d] got=%h exp=%h", i, result, res(int'(exp_idx[i]))); end
            total++; if (ext !== s_ext[exp_idx[i]]) begin bad++; $display("FAIL rr_ext[%0d] got=%b exp=%b", i, ext, s_ext[exp_idx[i]]); end
            $display("txn rr grant %0d: idx=%0d", i, out_idx);
            tick;
        end
        s_out_valid = '0; out_ready = 0;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rr_busy_end got=%b exp=0", busy); end
        total++; if (dut.cnt_q !== 4'd0) begin bad++; $display("FAIL rr_cnt_end got=%0d exp=0", dut.cnt_q); end
    endtask

    task automatic test_reset_with_flush;
        in_valid = 1; in_fmt = 2;
        tick;
        in_valid = 0; rst = 1; flush = 1;
        tick;
        rst = 0; flush = 0;
        #1;
        total++; if (dut.cnt_q !== 4'd0) begin bad++; $display("FAIL rstflush_cnt got=%0d exp=0", dut.cnt_q); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstflush_busy got=%b exp=0", busy); end
        $display("txn reset+flush: cnt=%0d", dut.cnt_q);
    endtask

    initial begin
        rst = 1; in_valid = 0; in_fmt = 0; flush = 0; out_ready = 0;
        s_in_ready = '1; s_out_valid = '0; s_ext = 5'b10101;
        for (int k = 0; k < NS; k++) begin
            s_result[k] = res(k);
            s_status[k] = status_t'(5'(k + 1));
            s_tag[k]    = k[0];
        end
        test_reset;
        test_dispatch;
        test_full;
        test_lock;
        test_simultaneous;
        test_flush;
        test_round_robin;
        test_reset_with_flush;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fpnew_opgroup_fmt_sched.md
Name: fpnew_opgroup_fmt_sched

Overview:
Scheduler in front of and behind the per-format slices of one operation group. It dispatches each incoming operation to the slice selected by its FP format and bounds the number of operations in flight. It merges the slices' variable-latency result streams into one output using a round-robin arbiter with grant lock. It sits between the top-level FPU op dispatch and the NumSlices format slices of an opgroup block.

Parameters:
NumSlices, fpnew_pkg::NUM_FP_FORMATS (5), number of format slices served (>=2)
Width, 64, result width
MaxInFlight, 8, maximum outstanding operations across all slices (>=1)
TagType, logic, tag type carried with each result
IdxWidth, derived $clog2(NumSlices), slice index width (localparam)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
in_valid_i  in  1  operation valid
in_fmt_i  in  IdxWidth  target slice index
in_ready_o  out  1  operation accepted
flush_i  in  1  kill all in-flight state
slice_in_valid_o  out  NumSlices  per-slice input valid
slice_in_ready_i  in  NumSlices  per-slice input ready
slice_result_i  in  NumSlices x Width  slice results
slice_status_i  in  NumSlices x fpnew_pkg::status_t  slice status flags
slice_ext_bit_i  in  NumSlices  slice extension bits
slice_tag_i  in  NumSlices x TagType  slice tags
slice_out_valid_i  in  NumSlices  slice result valid
slice_out_ready_o  out  NumSlices  slice result ready
result_o  out  Width  merged result
status_o  out  fpnew_pkg::status_t  merged status
extension_bit_o  out  1  merged extension bit
tag_o  out  TagType  merged tag
out_idx_o  out  IdxWidth  slice producing current output
out_valid_o  out  1  merged result valid
out_ready_i  in  1  downstream ready
busy_o  out  1  ops outstanding

Behaviour:
- State: cnt_q (0..MaxInFlight), rr_ptr_q (IdxWidth), lock_q (1), lock_idx_q (IdxWidth).
- Reset (rst_i=1 at edge): cnt_q=0, rr_ptr_q=0, lock_q=0, lock_idx_q=0. While rst_i is high, in_ready_o, slice_in_valid_o, slice_out_ready_o and out_valid_o are all forced 0. busy_o follows cnt_q and is 0 after reset. Data outputs are don't-care while invalid, but result_o, status_o, extension_bit_o and tag_o are driven from slice 0 when nothing is granted (no X propagation).
- Dispatch (combinational, 0 latency):
  - slice_in_valid_o[k] = in_valid_i & (in_fmt_i==k) & ~full & ~flush_i.
  - in_ready_o = slice_in_ready_i[in_fmt_i] & ~full & ~flush_i.
  - full = (cnt_q==MaxInFlight). There is no same-cycle bypass: a full counter blocks input even if an output fires that cycle.
  - in_fmt_i >= NumSlices: no slice_in_valid_o asserted, in_ready_o=0. This is a protocol violation and is caught by an assertion.
- Arbitration (combinational grant):
  - lock_q=1: grant=lock_idx_q.
  - Otherwise: grant is the first k with slice_out_valid_i[k], searching rr_ptr_q, rr_ptr_q+1, ... and wrapping modulo NumSlices.
  - out_valid_o = any valid & ~flush_i. Data outputs are muxed from grant; out_idx_o=grant.
  - slice_out_ready_o[grant] = out_ready_i & ~flush_i; all other slices get 0.
- Lock: out_valid_o & ~out_ready_i sets lock_q<=1 and lock_idx_q<=grant. The output fire clears lock_q. Output data and out_idx_o therefore stay stable until accepted, even if a higher-priority slice becomes valid.
- Pointer: on output fire, rr_ptr_q <= (grant==NumSlices-1) ? 0 : grant+1. Otherwise rr_ptr_q holds.
- Counter update:
  - in fire only: +1; out fire only: -1; both: unchanged.
  - Out fire with cnt_q==0 keeps cnt_q at 0 and is flagged by an assertion.
  - Counter can never exceed MaxInFlight (guaranteed by full).
- busy_o = (cnt_q!=0).
- Flush (flush_i=1): all handshakes are masked that cycle. Next cycle cnt_q=0, lock_q=0, rr_ptr_q=0. The slices receive flush in parallel; the scheduler does not drive their flush.
- Reset and flush asserted together: reset wins; the end state is identical.

Decomposition:
- fpnew_pkg: reuse status_t and NUM_FP_FORMATS. Add function rr_next(idx, n) returning the wrapped increment, so other arbiters can share it.
- Sub-module fpnew_rr_lock_arbiter holds rr_ptr_q, lock_q, lock_idx_q, the grant search and the handshake gating, parameterised on NumReq and a data type.
- The top level keeps the dispatch decode, the in-flight counter and the output muxing.

Test Plan:
- Reset then idle: after rst_i, in_valid_i=1, fmt=2, slice_in_ready_i=all 1 -> slice_in_valid_o=5'b00100, in_ready_o=1; next cycle busy_o=1, cnt_q=1.
- Full stall: MaxInFlight=8, issue 8 ops, no outputs -> 9th has in_ready_o=0. Complete 1 result -> in_ready_o=1 the following cycle, not the same cycle.
- Round-robin fairness: slices 0,1,3 valid continuously, out_ready_i=1, rr_ptr_q=0 -> out_idx_o sequence 0,1,3,0,1,3.
- Lock under backpressure: slice 3 granted with out_ready_i=0, then slice 0 becomes valid -> out_idx_o stays 3 and result_o is unchanged until out_ready_i=1. Next grant is 0 (ptr wrapped to 4 and 4 not valid, so the search wraps to 0).
- Simultaneous in/out fire at cnt_q=5 -> cnt_q stays 5. Out fire at cnt_q=1 with no input -> busy_o=0 next cycle.
- Flush mid-operation: cnt_q=6, lock_q=1, flush_i=1 -> that cycle out_valid_o=0 and in_ready_o=0. Next cycle cnt_q=0, lock_q=0, rr_ptr_q=0, busy_o=0.
